stack_seq: RTL and testbench

Multi-cycle stack sequencer for CALL, RET, INT and RTI. It owns the stack pointer and drives the 16-bit data memory through two or three single-word stack accesses per operation. It emits the phase code and stack-type flags consumed directly downstream by the PC/flags accumulator, which assembles popped words into a 32-bit PC and 3-bit flags. It also freezes the pipeline while a sequence runs.

---
 rtl/stack_seq.sv | 143 ++++++++++++++
 tb/tb_stack_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq.sv
// Stack sequencer for CALL/RET/INT/RTI: walks the phase codes 11/10/01 and drives one stack word access per phase.
// Latency: first phase the cycle after start is accepted; done pulses 3 (CALL/RET) or 4 (INT/RTI) cycles after acceptance.
// Backpressure: hold freezes state, sp and operands and suppresses memory strobes; start is ignored unless idle and not held.
module stack_seq #(
  parameter logic [31:0] SP_INIT = 32'h000F_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] pc_in,
  input  logic [2:0]  flags_in,
  input  logic        hold,
  output logic [1:0]  phase,
  output logic        stack_pc,
  output logic        stack_flags,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [31:0] sp,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  // IDLE and DONE both present phase 00; the three active states map onto the downstream phase codes.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P11  = 3'd1,
    S_P10  = 3'd2,
    S_P01  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state;
  logic        pop_q;    // RET/RTI pop; CALL/INT push (op bit 0)
  logic [31:0] pc_q;
  logic [2:0]  flags_q;

  logic        in_phase;
  logic        access;
  logic [31:0] sp_step;

  assign in_phase = (state == S_P11) || (state == S_P10) || (state == S_P01);
  assign access   = in_phase && !hold;
  // Pops pre-increment, pushes post-decrement; both wrap modulo 2^32.
  assign sp_step  = pop_q ? (sp + 32'd1) : (sp - 32'd1);

  assign mem_read  = access && pop_q;
  assign mem_write = access && !pop_q;
  assign stall     = busy | (start & ~busy);

  // Address and push data follow the current phase; zero outside an active phase.
  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 16'd0;
    if (in_phase) begin
      mem_addr = pop_q ? (sp + 32'd1) : sp;
      if (!pop_q) begin
        case (state)
          S_P11:   mem_wdata = {13'd0, flags_q};
          S_P10:   mem_wdata = pc_q[31:16];
          S_P01:   mem_wdata = pc_q[15:0];
          default: mem_wdata = 16'd0;
        endcase
      end
    end
  end

  // Sequencer FSM with registered phase, stack-type flags, busy and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sp          <= SP_INIT;
      pop_q       <= 1'b0;
      pc_q        <= 32'd0;
      flags_q     <= 3'd0;
      phase       <= 2'b00;
      stack_pc    <= 1'b0;
      stack_flags <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !hold) begin
            pop_q       <= op[0];
            pc_q        <= pc_in;
            flags_q     <= flags_in;
            stack_pc    <= 1'b1;
            stack_flags <= op[1];
            busy        <= 1'b1;
            if (op[1]) begin
              state <= S_P11;
              phase <= 2'b11;
            end else begin
              state <= S_P10;
              phase <= 2'b10;
            end
          end
        end
        S_P11: begin
          if (!hold) begin
            sp    <= sp_step;
            state <= S_P10;
            phase <= 2'b10;
          end
        end
        S_P10: begin
          if (!hold) begin
            sp    <= sp_step;
            state <= S_P01;
            phase <= 2'b01;
          end
        end
        S_P01: begin
          if (!hold) begin
            sp          <= sp_step;
            state       <= S_DONE;
            phase       <= 2'b00;
            stack_pc    <= 1'b0;
            stack_flags <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state       <= S_IDLE;
          phase       <= 2'b00;
          stack_pc    <= 1'b0;
          stack_flags <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: two instances (default SP_INIT and an all-ones SP_INIT) share stimulus.
// Each operation is checked cycle by cycle against a transaction-level stack model.
// Directed cases cover the listed scenarios; a random section mixes ops, operands and holds.
module tb_stack_seq;

  localparam logic [1:0] OP_CALL = 2'b00;
  localparam logic [1:0] OP_RET  = 2'b01;
  localparam logic [1:0] OP_INT  = 2'b10;
  localparam logic [1:0] OP_RTI  = 2'b11;

  logic        clk = 1'b0;
  logic        rst, start, hold;
  logic [1:0]  op;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;

  logic [1:0]  phase [2];
  logic        stack_pc [2];
  logic        stack_flags [2];
  logic        mem_read [2];
  logic        mem_write [2];
  logic [31:0] mem_addr [2];
  logic [15:0] mem_wdata [2];
  logic [31:0] sp [2];
  logic        busy [2];
  logic        stall [2];
  logic        done [2];

  logic [31:0] m_sp [2];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_seq u_dut0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .pc_in(pc_in), .flags_in(flags_in), .hold(hold),
    .phase(phase[0]), .stack_pc(stack_pc[0]), .stack_flags(stack_flags[0]), .mem_read(mem_read[0]),
    .mem_write(mem_write[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .sp(sp[0]),
    .busy(busy[0]), .stall(stall[0]), .done(done[0])
  );

  stack_seq #(.SP_INIT(32'hFFFF_FFFF)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .pc_in(pc_in), .flags_in(flags_in), .hold(hold),
    .phase(phase[1]), .stack_pc(stack_pc[1]), .stack_flags(stack_flags[1]), .mem_read(mem_read[1]),
    .mem_write(mem_write[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .sp(sp[1]),
    .busy(busy[1]), .stall(stall[1]), .done(done[1])
  );

  function automatic logic [31:0] init_sp(input int i);
    return (i == 0) ? 32'h000F_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input int i, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%b expected=%b", tag, i, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_phase"}, i, 32'(phase[i]), 32'd0);
      chk1({tag, "_busy"}, i, busy[i], 1'b0);
      chk1({tag, "_rd"}, i, mem_read[i], 1'b0);
      chk1({tag, "_wr"}, i, mem_write[i], 1'b0);
      chk1({tag, "_spc"}, i, stack_pc[i], 1'b0);
      chk1({tag, "_sfl"}, i, stack_flags[i], 1'b0);
      chk({tag, "_sp"}, i, sp[i], m_sp[i]);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; hold = 1'b0; op = 2'b00; pc_in = 32'd0; flags_in = 3'd0;
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) m_sp[i] = init_sp(i);
    @(negedge clk);
    chk_quiet("rst");
    for (int i = 0; i < 2; i++) begin
      chk1("rst_done", i, done[i], 1'b0);
      chk("rst_addr", i, mem_addr[i], 32'd0);
      chk("rst_wdata", i, 32'(mem_wdata[i]), 32'd0);
      chk1("rst_stall", i, stall[i], 1'b0);
    end
    tick;
  endtask

  // One full operation; hold asserted for hold_len cycles at phase index hold_k;
  // poke pulses a stray start during the last phase.
  task automatic do_op(input logic [1:0] o, input logic [31:0] pc, input logic [2:0] fl,
                       input int hold_k, input int hold_len, input bit poke);
    int n;
    logic [15:0] w [3];
    logic [31:0] a;
    n = o[1] ? 3 : 2;
    if (o == OP_INT) begin
      w[0] = {13'd0, fl}; w[1] = pc[31:16]; w[2] = pc[15:0];
    end else begin
      w[0] = pc[31:16]; w[1] = pc[15:0]; w[2] = 16'd0;
    end
    start = 1'b1; op = o; pc_in = pc; flags_in = fl;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk1("start_stall", i, stall[i], 1'b1);
      chk1("start_busy", i, busy[i], 1'b0);
      chk1("start_done", i, done[i], 1'b0);
    end
    tick;
    start = 1'b0; op = 2'($urandom); pc_in = $urandom; flags_in = 3'($urandom);
    for (int k = 0; k < n; k++) begin
      if (k == hold_k) begin
        for (int h = 0; h < hold_len; h++) begin
          hold = 1'b1;
          @(negedge clk);
          for (int i = 0; i < 2; i++) begin
            chk("hold_phase", i, 32'(phase[i]), 32'(n - k));
            chk1("hold_busy", i, busy[i], 1'b1);
            chk1("hold_rd", i, mem_read[i], 1'b0);
            chk1("hold_wr", i, mem_write[i], 1'b0);
            chk1("hold_spc", i, stack_pc[i], 1'b1);
            chk1("hold_sfl", i, stack_flags[i], o[1]);
            chk1("hold_done", i, done[i], 1'b0);
          end
          tick;
        end
        hold = 1'b0;
      end
      if (poke && k == n - 1) begin
        start = 1'b1; op = 2'($urandom);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        a = o[0] ? (m_sp[i] + 32'(k + 1)) : (m_sp[i] - 32'(k));
        chk("ph_phase", i, 32'(phase[i]), 32'(n - k));
        chk1("ph_busy", i, busy[i], 1'b1);
        chk1("ph_stall", i, stall[i], 1'b1);
        chk1("ph_spc", i, stack_pc[i], 1'b1);
        chk1("ph_sfl", i, stack_flags[i], o[1]);
        chk1("ph_rd", i, mem_read[i], o[0]);
        chk1("ph_wr", i, mem_write[i], !o[0]);
        chk("ph_addr", i, mem_addr[i], a);
        if (!o[0]) chk("ph_wdata", i, 32'(mem_wdata[i]), 32'(w[k]));
        chk1("ph_done", i, done[i], 1'b0);
      end
      tick;
      start = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      m_sp[i] = o[0] ? (m_sp[i] + 32'(n)) : (m_sp[i] - 32'(n));
      chk1("fin_done", i, done[i], 1'b1);
      chk1("fin_stall", i, stall[i], 1'b0);
    end
    chk_quiet("fin");
    tick;
    if (poke) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        chk_quiet("poke");
        for (int i = 0; i < 2; i++) chk1("poke_done", i, done[i], 1'b0);
        tick;
      end
    end
  endtask

  initial begin
    int o_r, hk, hl;
    do_reset;
    // RET straight from reset: dut1 wraps to addresses 0 and 1; stray start in P01 ignored
    do_op(OP_RET, 32'd0, 3'd0, -1, 0, 1'b1);
    chk("wrap_sp", 1, sp[1], 32'h0000_0001);

    do_reset;
    // CALL held for two cycles in P10, then RET back, INT push, RTI pop
    do_op(OP_CALL, 32'hCAFE_0001, 3'd0, 0, 2, 1'b0);
    chk("call_sp", 0, sp[0], 32'h000F_FFFD);
    do_op(OP_RET, 32'd0, 3'd0, -1, 0, 1'b0);
    chk("ret_sp", 0, sp[0], 32'h000F_FFFF);
    do_op(OP_INT, 32'h1234_5678, 3'b101, -1, 0, 1'b0);
    chk("int_sp", 0, sp[0], 32'h000F_FFFC);
    do_op(OP_RTI, 32'd0, 3'd0, -1, 0, 1'b0);
    chk("rti_sp", 0, sp[0], 32'h000F_FFFF);

    // hold in IDLE blocks start
    hold = 1'b1; start = 1'b1; op = OP_INT;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk1("idlehold_stall", i, stall[i], 1'b1);
    tick;
    hold = 1'b0; start = 1'b0;
    @(negedge clk);
    chk_quiet("idlehold");
    tick;

    // randomized operations with random hold placement
    for (int r = 0; r < 24; r++) begin
      o_r = $urandom_range(0, 3);
      hk  = $urandom_range(0, 4);
      hl  = $urandom_range(1, 3);
      do_op(2'(o_r), $urandom, 3'($urandom_range(0, 7)), hk, hl, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of an RTI
    start = 1'b1; op = OP_RTI;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("mid_phase_before", i, 32'(phase[i]), 32'd2);
      chk1("mid_rd_before", i, mem_read[i], 1'b1);
    end
    tick;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) m_sp[i] = init_sp(i);
    @(negedge clk);
    chk_quiet("midrst");
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
